// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin frame arbiter sharing one UART transmit byte stream
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   req_data           NREQ bytes, requester i on [8i+7:8i]
//   req_valid/last     per-requester byte valid / final byte of frame
//   req_ready          per-requester accept (combinational)
//   tx_tdata/tvalid    registered byte to the UART
//   tx_tready          UART accepts tx_tdata
//   grant              one-hot frame owner, zero when idle
//   busy               frame in progress or output register full
//   frame_abort        one-cycle pulse after a gap-timeout revocation
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int MAX_GAP = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_tdata,
    output logic              tx_tvalid,
    input  logic              tx_tready,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              frame_abort
);

    localparam int PW = $clog2(NREQ);
    localparam int GW = $clog2(MAX_GAP + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [GW-1:0] gap_cnt;

    logic [PW-1:0] win;
    logic          found;
    logic          owner_valid;
    logic          owner_last;
    logic [7:0]    owner_data;
    logic          accept;
    logic          timeout;

    // grant is zero outside OWN, so it alone gates readiness; no data path feeds this.
    assign req_ready   = grant & req_valid & {NREQ{~tx_tvalid | tx_tready}};
    assign accept      = |req_ready;

    // While owning, ptr holds the owner index.
    assign owner_valid = req_valid[ptr];
    assign owner_last  = req_last[ptr];
    assign owner_data  = req_data[int'(ptr)*8 +: 8];

    // An accept in the same cycle wins over the timeout so no byte is lost.
    assign timeout     = (state == OWN) && (gap_cnt == GW'(MAX_GAP)) && !accept;
    assign busy        = (state == OWN) | tx_tvalid;

    // Circular scan starting one past the last winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            grant       <= '0;
            ptr         <= PW'(NREQ - 1);
            gap_cnt     <= '0;
            tx_tvalid   <= 1'b0;
            tx_tdata    <= '0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= 1'b0;

            // Load has priority over drain, so load+drain keeps tvalid high.
            if (accept) begin
                tx_tdata  <= owner_data;
                tx_tvalid <= 1'b1;
            end else if (tx_tready) begin
                tx_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        ptr     <= win;
                        gap_cnt <= '0;
                        state   <= OWN;
                    end
                end
                OWN: begin
                    if (accept) begin
                        gap_cnt <= '0;
                        if (owner_last) begin
                            grant <= '0;
                            state <= IDLE;
                        end
                    end else if (timeout) begin
                        grant       <= '0;
                        gap_cnt     <= '0;
                        state       <= IDLE;
                        frame_abort <= 1'b1;
                    end else if (!owner_valid && gap_cnt != GW'(MAX_GAP)) begin
                        // Back-pressured cycles (valid high, not ready) leave the count alone.
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk;
    logic        nrst;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [3:0]  grant;
    logic        busy;
    logic        frame_abort;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NREQ(4), .MAX_GAP(8)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_tdata    (tx_tdata),
        .tx_tvalid   (tx_tvalid),
        .tx_tready   (tx_tready),
        .grant       (grant),
        .busy        (busy),
        .frame_abort (frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[i*8 +: 8] = b;
    endtask

    int rr_order [5] = '{3, 0, 1, 2, 3};

    initial begin
        nrst      = 1'b0;
        req_data  = '0;
        req_valid = '0;
        req_last  = '0;
        tx_tready = 1'b1;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_tvalid", 32'(tx_tvalid), 0);
        chk("rst_tdata", 32'(tx_tdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_abort", 32'(frame_abort), 0);
        chk("rst_ready", 32'(req_ready), 0);
        nrst = 1'b1;

        // Single requester 2: 0x41,0x42,0x43
        req_valid = 4'b0100;
        set_byte(2, 8'h41);
        settle();
        chk("s1_c0_grant", 32'(grant), 0);
        tick();
        chk("s1_c1_grant", 32'(grant), 32'h4);
        chk("s1_c1_ready", 32'(req_ready), 32'h4);
        tick();
        chk("s1_c2_tdata", 32'(tx_tdata), 32'h41);
        chk("s1_c2_tvalid", 32'(tx_tvalid), 1);
        set_byte(2, 8'h42);
        settle();
        chk("s1_c2_ready", 32'(req_ready), 32'h4);
        tick();
        chk("s1_c3_tdata", 32'(tx_tdata), 32'h42);
        set_byte(2, 8'h43);
        req_last = 4'b0100;
        tick();
        chk("s1_c4_tdata", 32'(tx_tdata), 32'h43);
        chk("s1_c4_grant", 32'(grant), 0);
        chk("s1_c4_busy", 32'(busy), 1);
        req_valid = '0;
        req_last  = '0;
        tick();
        chk("s1_c5_tvalid", 32'(tx_tvalid), 0);
        chk("s1_c5_busy", 32'(busy), 0);

        // Round robin: all requesters, 1-byte frames; last owner was 2
        for (int i = 0; i < 4; i++) set_byte(i, 8'hA0 + 8'(i));
        req_last  = 4'b1111;
        req_valid = 4'b1111;
        settle();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(1) << rr_order[k]);
            chk("rr_ready", 32'(req_ready), 32'(1) << rr_order[k]);
            tick();
            chk("rr_idle_grant", 32'(grant), 0);
            chk("rr_tdata", 32'(tx_tdata), 32'hA0 + 32'(rr_order[k]));
            chk("rr_tvalid", 32'(tx_tvalid), 1);
            if (k == 4) begin
                req_valid = '0;
                req_last  = '0;
            end
        end

        // Frame atomicity: requester 1 four bytes while requester 0 waits
        req_valid = 4'b0010;
        set_byte(1, 8'h11);
        settle();
        tick();
        chk("fa_grant1", 32'(grant), 32'h2);
        req_valid = 4'b0011;
        set_byte(0, 8'h55);
        req_last = 4'b0001;
        settle();
        for (int b = 0; b < 4; b++) begin
            set_byte(1, 8'h11 + 8'(b));
            req_last[1] = (b == 3);
            settle();
            chk("fa_ready", 32'(req_ready), 32'h2);
            tick();
            chk("fa_tdata", 32'(tx_tdata), 32'h11 + 32'(b));
            chk("fa_grant", 32'(grant), (b == 3) ? 0 : 32'h2);
        end
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        settle();
        tick();
        chk("fa_grant0", 32'(grant), 32'h1);
        tick();
        chk("fa_tdata0", 32'(tx_tdata), 32'h55);
        chk("fa_grant_clr", 32'(grant), 0);
        req_valid = '0;
        req_last  = '0;

        // Back-pressure: 10 cycles of tx_tready low mid-frame
        req_valid = 4'b0010;
        set_byte(1, 8'h21);
        settle();
        tick();
        chk("bp_grant", 32'(grant), 32'h2);
        tick();
        chk("bp_tdata0", 32'(tx_tdata), 32'h21);
        set_byte(1, 8'h22);
        tx_tready = 1'b0;
        settle();
        for (int c = 0; c < 10; c++) begin
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_tdata", 32'(tx_tdata), 32'h21);
            chk("bp_tvalid", 32'(tx_tvalid), 1);
            chk("bp_gap", 32'(dut.gap_cnt), 0);
            tick();
        end
        tx_tready = 1'b1;
        settle();
        chk("bp_ready_back", 32'(req_ready), 32'h2);
        tick();
        chk("bp_tdata1", 32'(tx_tdata), 32'h22);
        set_byte(1, 8'h23);
        req_last = 4'b0010;
        tick();
        chk("bp_tdata2", 32'(tx_tdata), 32'h23);
        chk("bp_grant_clr", 32'(grant), 0);
        req_valid = '0;
        req_last  = '0;
        tick();
        chk("bp_tvalid_clr", 32'(tx_tvalid), 0);
        chk("bp_busy", 32'(busy), 0);

        // Gap timeout: owner 3 sends one non-last byte then goes quiet
        req_valid = 4'b1000;
        set_byte(3, 8'h77);
        settle();
        tick();
        chk("gt_grant3", 32'(grant), 32'h8);
        tick();
        chk("gt_tdata", 32'(tx_tdata), 32'h77);
        chk("gt_tvalid", 32'(tx_tvalid), 1);
        req_valid = 4'b0001;
        set_byte(0, 8'h99);
        req_last = 4'b0001;
        settle();
        chk("gt_mask", 32'(req_ready), 0);
        for (int c = 2; c <= 10; c++) begin
            chk("gt_hold_grant", 32'(grant), 32'h8);
            chk("gt_no_abort", 32'(frame_abort), 0);
            chk("gt_gap", 32'(dut.gap_cnt), 32'(c - 2));
            tick();
        end
        chk("gt_grant_clr", 32'(grant), 0);
        chk("gt_abort", 32'(frame_abort), 1);
        chk("gt_busy", 32'(busy), 0);
        tick();
        chk("gt_abort_once", 32'(frame_abort), 0);
        chk("gt_next_grant", 32'(grant), 32'h1);
        tick();
        chk("gt_next_tdata", 32'(tx_tdata), 32'h99);
        req_valid = '0;
        req_last  = '0;

        // Reset mid-frame with a byte pending
        req_valid = 4'b0010;
        set_byte(1, 8'h31);
        settle();
        tick();
        chk("rm_grant", 32'(grant), 32'h2);
        tick();
        chk("rm_tvalid", 32'(tx_tvalid), 1);
        tx_tready = 1'b0;
        nrst = 1'b0;
        settle();
        chk("rm_grant0", 32'(grant), 0);
        chk("rm_tvalid0", 32'(tx_tvalid), 0);
        chk("rm_tdata0", 32'(tx_tdata), 0);
        chk("rm_busy0", 32'(busy), 0);
        chk("rm_ready0", 32'(req_ready), 0);
        chk("rm_abort0", 32'(frame_abort), 0);
        req_valid = 4'b0101;
        req_last  = 4'b0101;
        set_byte(0, 8'hC0);
        set_byte(2, 8'hC2);
        tx_tready = 1'b1;
        tick();
        chk("rm_held", 32'(grant), 0);
        nrst = 1'b1;
        tick();
        chk("rm_scan0", 32'(grant), 32'h1);
        tick();
        chk("rm_tdata", 32'(tx_tdata), 32'hC0);
        req_valid = '0;
        req_last  = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
